// File: rtl/commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : commit_ctrl
// Purpose  : In-order retirement sequencer (ROB head -> register file commit,
//            store handshake, mispredict clear/redirect with flush window).
//            Optional perf counters enabled by COMMIT_CTRL_PERF_EN.
// Revision : 1.0
// ============================================================================
module commit_ctrl #(
    parameter int TAG_W        = 4,
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             head_valid,
    output logic             head_ready,
    input  logic [TAG_W-1:0] head_tag,
    input  logic [1:0]       head_kind,
    input  logic [4:0]       head_rd,
    input  logic [XLEN-1:0]  head_val,
    input  logic             head_mispredict,
    input  logic [XLEN-1:0]  head_target,
    output logic             st_req,
    output logic [TAG_W-1:0] st_tag,
    input  logic             st_done,
    output logic             commit_sig,
    output logic [4:0]       commit_reg,
    output logic [XLEN-1:0]  commit_val,
    output logic [TAG_W-1:0] commit_rob_tag,
    output logic             clear,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc
`ifdef COMMIT_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_retired,
    output logic [15:0]      perf_flushes
`endif
);

    localparam int                CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [1:0]        KIND_REG = 2'b00;
    localparam logic [1:0]        KIND_ST  = 2'b01;
    localparam logic [1:0]        KIND_BR  = 2'b10;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_ST_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              st_req_q;
    logic [TAG_W-1:0]  st_tag_q;
    logic              commit_sig_q;
    logic [4:0]        commit_reg_q;
    logic [XLEN-1:0]   commit_val_q;
    logic [TAG_W-1:0]  commit_tag_q;
    logic              clear_q;
    logic              redir_valid_q;
    logic [XLEN-1:0]   redir_pc_q;

    logic pop;
    logic run_pop;
    logic is_wb;
    logic is_mis;

    // Gated by rst_n so the pop strobe drops the instant reset asserts.
    always_comb begin
        head_ready = 1'b0;
        case (state_q)
            S_RUN:     head_ready = rdy && head_valid && (head_kind != KIND_ST);
            S_ST_WAIT: head_ready = rdy && st_done;
            default:   head_ready = 1'b0;
        endcase
        head_ready = head_ready && rst_n;
    end

    assign pop     = head_valid && head_ready;
    assign run_pop = pop && (state_q == S_RUN);
    assign is_wb   = (head_kind == KIND_REG) || (head_kind == KIND_BR);
    assign is_mis  = (head_kind == KIND_BR) && head_mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            cnt_q         <= '0;
            st_req_q      <= 1'b0;
            st_tag_q      <= '0;
            commit_sig_q  <= 1'b0;
            commit_reg_q  <= '0;
            commit_val_q  <= '0;
            commit_tag_q  <= '0;
            clear_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            commit_sig_q  <= 1'b0;
            clear_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            if (rdy) begin
                if (run_pop && is_wb) begin
                    commit_sig_q <= (head_rd != 5'd0);
                    commit_reg_q <= head_rd;
                    commit_val_q <= head_val;
                    commit_tag_q <= head_tag;
                end
                if (run_pop && is_mis) begin
                    clear_q       <= 1'b1;
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= head_target;
                end
                case (state_q)
                    S_RUN: begin
                        if (run_pop && is_mis) begin
                            state_q <= S_FLUSH;
                            cnt_q   <= CNT_LOAD;
                        end else if (head_valid && (head_kind == KIND_ST)) begin
                            state_q  <= S_ST_WAIT;
                            st_req_q <= 1'b1;
                            st_tag_q <= head_tag;
                        end
                    end
                    S_ST_WAIT: begin
                        if (st_done) begin
                            state_q  <= S_RUN;
                            st_req_q <= 1'b0;
                        end
                    end
                    S_FLUSH: begin
                        if (cnt_q == '0) begin
                            state_q <= S_RUN;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: state_q <= S_RUN;
                endcase
            end
        end
    end

    assign st_req         = st_req_q;
    assign st_tag         = st_tag_q;
    assign commit_sig     = commit_sig_q;
    assign commit_reg     = commit_reg_q;
    assign commit_val     = commit_val_q;
    assign commit_rob_tag = commit_tag_q;
    assign clear          = clear_q;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;

`ifdef COMMIT_CTRL_PERF_EN
    logic [31:0] perf_retired_q;
    logic [15:0] perf_flushes_q;

    // pop already implies rdy, so both counters freeze while rdy=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (pop) begin
                perf_retired_q <= perf_retired_q + 32'd1;
            end
            if (run_pop && is_mis) begin
                perf_flushes_q <= perf_flushes_q + 16'd1;
            end
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_ctrl.sv
`default_nettype none
// tb_commit_ctrl: randomized ROB-head driver, memory responder and a
// scoreboard/reference model of in-order retirement for commit_ctrl.
module tb_commit_ctrl;

    localparam int FC = 2;

    typedef struct {
        logic [3:0]  tag;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        mis;
        logic [31:0] tgt;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b0;
    logic        head_valid = 1'b0;
    logic        head_ready;
    logic [3:0]  head_tag = '0;
    logic [1:0]  head_kind = '0;
    logic [4:0]  head_rd = '0;
    logic [31:0] head_val = '0;
    logic        head_mispredict = 1'b0;
    logic [31:0] head_target = '0;
    logic        st_req;
    logic [3:0]  st_tag;
    logic        st_done = 1'b0;
    logic        commit_sig;
    logic [4:0]  commit_reg;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_tag;
    logic        clear;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef COMMIT_CTRL_PERF_EN
    logic [31:0] perf_retired;
    logic [15:0] perf_flushes;
`endif

    commit_ctrl #(.TAG_W(4), .XLEN(32), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .head_valid(head_valid), .head_ready(head_ready), .head_tag(head_tag),
        .head_kind(head_kind), .head_rd(head_rd), .head_val(head_val),
        .head_mispredict(head_mispredict), .head_target(head_target),
        .st_req(st_req), .st_tag(st_tag), .st_done(st_done),
        .commit_sig(commit_sig), .commit_reg(commit_reg), .commit_val(commit_val),
        .commit_rob_tag(commit_rob_tag), .clear(clear),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef COMMIT_CTRL_PERF_EN
        , .perf_retired(perf_retired), .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Program still to be retired, and expected responses in program order.
    ent_t        prog[$];
    ent_t        exp_commit[$];
    logic [31:0] exp_redir[$];
    logic [3:0]  exp_store[$];

    int unsigned rdy_pct = 100, vld_pct = 100, done_pct = 30;
    bit drv_en = 1'b1;
    bit mon_en = 1'b0;

    task automatic gen(input logic [3:0] tag, input logic [1:0] kind, input logic [4:0] rd,
                       input logic [31:0] val, input logic mis, input logic [31:0] tgt);
        ent_t e;
        e.tag = tag; e.kind = kind; e.rd = rd; e.val = val; e.mis = mis; e.tgt = tgt;
        prog.push_back(e);
        if ((kind == 2'b00 || kind == 2'b10) && rd != 5'd0) exp_commit.push_back(e);
        if (kind == 2'b10 && mis) exp_redir.push_back(tgt);
        if (kind == 2'b01) exp_store.push_back(tag);
    endtask

    // Driver: ROB head presenter plus memory responder.
    always begin : drv
        bit   p;
        bit   hv;
        ent_t e;
        @(negedge clk);
        p = head_valid && head_ready;
        @(posedge clk);
        #1;
        if (drv_en) begin
            if (p && prog.size() > 0) begin
                prog.delete(0);
                hv = 1'b0;
            end
            if (prog.size() == 0) hv = 1'b0;
            rdy = ($urandom_range(0, 99) < rdy_pct);
            if (!hv && prog.size() > 0 && $urandom_range(0, 99) < vld_pct) hv = 1'b1;
            if (hv) begin
                e = prog[0];
                head_tag = e.tag; head_kind = e.kind; head_rd = e.rd;
                head_val = e.val; head_mispredict = e.mis; head_target = e.tgt;
            end else begin
                head_tag = 4'($urandom); head_kind = 2'($urandom); head_rd = 5'($urandom);
                head_val = $urandom; head_mispredict = 1'($urandom); head_target = $urandom;
            end
            head_valid = hv;
            st_done = st_req && ($urandom_range(0, 99) < done_pct);
        end
    end

    // Reference model state: architectural view of retirement.
    bit          m_pend;
    logic [3:0]  m_sttag;
    int          m_flush;
    bit          m_cs, m_clr;
    logic [4:0]  m_reg;
    logic [31:0] m_val, m_pc;
    logic [3:0]  m_tag;
    int unsigned m_retired, m_flushes;

    always @(negedge clk) begin : mon
        bit exp_hr, pop_m, in_flush, wb;
        ent_t c;
        if (!mon_en) begin
            m_pend = 0; m_sttag = '0; m_flush = 0; m_cs = 0; m_clr = 0;
            m_reg = '0; m_val = '0; m_pc = '0; m_tag = '0; m_retired = 0; m_flushes = 0;
        end else begin
            if (!rdy)             exp_hr = 1'b0;
            else if (m_flush > 0) exp_hr = 1'b0;
            else if (m_pend)      exp_hr = st_done;
            else                  exp_hr = head_valid && (head_kind != 2'b01);
            chk("head_ready", head_ready, exp_hr);
            chk("commit_sig", commit_sig, m_cs);
            chk("clear", clear, m_clr);
            chk("redirect_valid", redirect_valid, m_clr);
            chk("commit_reg", commit_reg, m_reg);
            chk("commit_val", commit_val, m_val);
            chk("commit_rob_tag", commit_rob_tag, m_tag);
            chk("redirect_pc", redirect_pc, m_pc);
            chk("st_req", st_req, m_pend);
            if (m_pend) chk("st_tag", st_tag, m_sttag);
`ifdef COMMIT_CTRL_PERF_EN
            chk("perf_retired", perf_retired, m_retired);
            chk("perf_flushes", perf_flushes, 16'(m_flushes));
`endif
            if (commit_sig) begin
                if (exp_commit.size() == 0) chk("sb_commit_unexpected", 1, 0);
                else begin
                    c = exp_commit.pop_front();
                    chk("sb_commit_reg", commit_reg, c.rd);
                    chk("sb_commit_val", commit_val, c.val);
                    chk("sb_commit_tag", commit_rob_tag, c.tag);
                end
            end
            if (redirect_valid) begin
                if (exp_redir.size() == 0) chk("sb_redirect_unexpected", 1, 0);
                else chk("sb_redirect_pc", redirect_pc, exp_redir.pop_front());
            end

            pop_m    = head_valid && exp_hr;
            in_flush = (m_flush > 0);
            wb       = (head_kind == 2'b00) || (head_kind == 2'b10);
            m_cs     = pop_m && !m_pend && wb && (head_rd != 5'd0);
            m_clr    = pop_m && !m_pend && (head_kind == 2'b10) && head_mispredict;
            if (pop_m && !m_pend && wb) begin
                m_reg = head_rd; m_val = head_val; m_tag = head_tag;
            end
            if (pop_m) m_retired++;
            if (m_clr) begin
                m_pc = head_target; m_flush = FC; m_flushes++;
            end else if (in_flush && rdy) begin
                m_flush--;
            end
            if (m_pend && rdy && st_done) begin
                m_pend = 0;
                if (exp_store.size() == 0) chk("sb_store_unexpected", 1, 0);
                else chk("sb_store_tag", st_tag, exp_store.pop_front());
            end else if (!m_pend && !in_flush && rdy && head_valid && head_kind == 2'b01) begin
                m_pend = 1; m_sttag = head_tag;
            end
        end
    end

    task automatic drain(input int limit);
        int n = 0;
        while ((prog.size() != 0 || m_pend || st_req) && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", n < limit, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic chk_all_zero(input string ph);
        chk({ph, "_head_ready"}, head_ready, 0);
        chk({ph, "_st_req"}, st_req, 0);
        chk({ph, "_st_tag"}, st_tag, 0);
        chk({ph, "_commit_sig"}, commit_sig, 0);
        chk({ph, "_commit_reg"}, commit_reg, 0);
        chk({ph, "_commit_val"}, commit_val, 0);
        chk({ph, "_commit_rob_tag"}, commit_rob_tag, 0);
        chk({ph, "_clear"}, clear, 0);
        chk({ph, "_redirect_valid"}, redirect_valid, 0);
        chk({ph, "_redirect_pc"}, redirect_pc, 0);
`ifdef COMMIT_CTRL_PERF_EN
        chk({ph, "_perf_retired"}, perf_retired, 0);
        chk({ph, "_perf_flushes"}, perf_flushes, 0);
`endif
    endtask

    initial begin
        int n;
        #3 rst_n = 1'b0;
        #1 chk_all_zero("por");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);

        // Directed program from the retirement scenarios.
        rdy_pct = 100; vld_pct = 100; done_pct = 30;
        gen(4'd1, 2'b00, 5'd5, 32'hA, 1'b0, 32'h0);
        gen(4'd2, 2'b00, 5'd6, 32'hB, 1'b0, 32'h0);
        gen(4'd3, 2'b00, 5'd0, 32'hC, 1'b0, 32'h0);
        gen(4'd4, 2'b01, 5'd9, 32'h44, 1'b1, 32'h0);
        gen(4'd7, 2'b10, 5'd1, 32'h100, 1'b1, 32'h2000);
        gen(4'd8, 2'b00, 5'd2, 32'h55, 1'b0, 32'h0);
        gen(4'd9, 2'b11, 5'd3, 32'h66, 1'b1, 32'h3000);
        drain(200);

        // Randomized traffic with rdy stalls inside store waits and flush windows.
        rdy_pct = 75; vld_pct = 70; done_pct = 40;
        for (int i = 0; i < 250; i++) begin
            logic [4:0] rd;
            rd = 5'($urandom);
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            gen(4'(i), 2'($urandom), rd, $urandom, ($urandom_range(0, 2) == 0), $urandom);
        end
        drain(20000);
        chk("commit_queue_empty", exp_commit.size(), 0);
        chk("redirect_queue_empty", exp_redir.size(), 0);
        chk("store_queue_empty", exp_store.size(), 0);

        // Asynchronous reset while a store is outstanding.
        rdy_pct = 100; vld_pct = 100; done_pct = 0;
        gen(4'd9, 2'b01, 5'd0, 32'h0, 1'b0, 32'h0);
        n = 0;
        while (!st_req && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("store_start_timeout", n < 50, 1);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1 chk_all_zero("midstore_reset");
        prog.delete();
        exp_commit.delete();
        exp_redir.delete();
        exp_store.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        done_pct = 50;
        gen(4'd10, 2'b00, 5'd4, 32'h1234, 1'b0, 32'h0);
        gen(4'd11, 2'b10, 5'd0, 32'h0, 1'b1, 32'h4000);
        gen(4'd12, 2'b00, 5'd8, 32'h99, 1'b0, 32'h0);
        drain(200);
        chk("final_commit_queue_empty", exp_commit.size(), 0);
        chk("final_redirect_queue_empty", exp_redir.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
